// File: rtl/ser_pkg.sv
// Shared types and constants for the serial word deserializer.
// Collect FSM states, output-register states and bit-order encodings.
package ser_pkg;

  typedef enum logic {S_IDLE, S_COLLECT} ser_state_e;

  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_e;

  localparam logic LSB_FIRST = 1'b1;
  localparam logic MSB_FIRST = 1'b0;

endpackage

// File: rtl/ser_out_hold.sv
// One-entry valid/ready holding register for completed words.
// A word that arrives while the entry is full and not being drained is dropped and flagged.
module ser_out_hold #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  input  logic             clear_ovf_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             overflow_o
);
  import ser_pkg::*;

  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ovf_q, ovf_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= OUT_EMPTY;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  // Clear is applied first so that a drop in the same cycle overrides it.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    if (clear_ovf_i) ovf_d = 1'b0;
    case (state_q)
      OUT_EMPTY: begin
        if (load_i) begin
          data_d  = data_i;
          state_d = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (load_i) begin
          if (ready_i) data_d = data_i;
          else         ovf_d  = 1'b1;
        end else if (ready_i) begin
          state_d = OUT_EMPTY;
        end
      end
      default: state_d = OUT_EMPTY;
    endcase
  end

  assign data_o     = data_q;
  assign valid_o    = (state_q == OUT_FULL);
  assign overflow_o = ovf_q;

endmodule

// File: rtl/serial_word_deserializer.sv
// Serial-to-parallel receiver: collects WIDTH bits LSB- or MSB-first into a word
// and hands each completed word to a one-entry valid/ready output register.
module serial_word_deserializer #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             lsb_first,
  input  logic             frame_start,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overflow,
  input  logic             clear_ovf,
  output logic [CNT_W-1:0] bit_count
);
  import ser_pkg::*;

  if (WIDTH < 2) begin : g_width_check
    $error("serial_word_deserializer: WIDTH must be at least 2");
  end

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             complete;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                 input logic m, input logic b);
    if (m == LSB_FIRST) return {b, cur[WIDTH-1:1]};
    else                return {cur[WIDTH-2:0], b};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      mode_q  <= MSB_FIRST;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // A frame_start bit always opens a fresh word, so it can never complete one.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    complete = 1'b0;
    if (frame_start) begin
      state_d = S_IDLE;
      shreg_d = '0;
      cnt_d   = '0;
      if (bit_valid) begin
        mode_d  = lsb_first;
        shreg_d = shift_in('0, lsb_first, bit_in);
        cnt_d   = CNT_W'(1);
        state_d = S_COLLECT;
      end
    end else if (bit_valid) begin
      case (state_q)
        S_IDLE: begin
          mode_d  = lsb_first;
          shreg_d = shift_in(shreg_q, lsb_first, bit_in);
          cnt_d   = CNT_W'(1);
          state_d = S_COLLECT;
        end
        S_COLLECT: begin
          shreg_d = shift_in(shreg_q, mode_q, bit_in);
          if (cnt_q == LAST_IDX) begin
            cnt_d    = '0;
            state_d  = S_IDLE;
            complete = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  ser_out_hold #(.WIDTH(WIDTH)) u_out_hold (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (complete),
    .data_i      (shreg_d),
    .ready_i     (word_ready),
    .clear_ovf_i (clear_ovf),
    .data_o      (word_out),
    .valid_o     (word_valid),
    .overflow_o  (overflow)
  );

  assign bit_count = cnt_q;

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Directed self-checking bench for serial_word_deserializer at WIDTH=4.
// Inputs change 1ns after each rising edge; outputs are checked there too.
module tb_serial_word_deserializer;

  logic       clk = 1'b0;
  logic       rst_n, bit_in, bit_valid, lsb_first, frame_start;
  logic       word_ready, clear_ovf;
  logic [3:0] word_out;
  logic       word_valid, overflow;
  logic [1:0] bit_count;

  int total = 0;
  int bad   = 0;

  serial_word_deserializer #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .lsb_first   (lsb_first),
    .frame_start (frame_start),
    .word_out    (word_out),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .overflow    (overflow),
    .clear_ovf   (clear_ovf),
    .bit_count   (bit_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one valid bit for one clock, then drop bit_valid.
  task automatic applyStimulus(input logic b, input logic lsb);
    bit_in    = b;
    lsb_first = lsb;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; lsb_first = 1'b0;
    frame_start = 1'b0; word_ready = 1'b0; clear_ovf = 1'b0;

    // Test 1: reset, including a reset that lands mid-word
    idle(2);
    checkOutput("rst_word_out", 32'(word_out), 32'h0);
    checkOutput("rst_valid", 32'(word_valid), 32'h0);
    checkOutput("rst_ovf", 32'(overflow), 32'h0);
    checkOutput("rst_count", 32'(bit_count), 32'h0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t1_partial_count", 32'(bit_count), 32'h2);
    rst_n = 1'b0; bit_valid = 1'b1; bit_in = 1'b1;
    idle(2);
    bit_valid = 1'b0;
    checkOutput("t1_midrst_count", 32'(bit_count), 32'h0);
    checkOutput("t1_midrst_valid", 32'(word_valid), 32'h0);
    checkOutput("t1_midrst_word", 32'(word_out), 32'h0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t1_pre_valid", 32'(word_valid), 32'h0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t1_word", 32'(word_out), 32'h9);
    checkOutput("t1_valid", 32'(word_valid), 32'h1);
    word_ready = 1'b1;
    tick();
    checkOutput("t1_drain", 32'(word_valid), 32'h0);

    // Test 2: LSB-first 1,0,1,1 -> 1101, one-cycle valid
    applyStimulus(1'b1, 1'b1);
    checkOutput("t2_cnt1", 32'(bit_count), 32'h1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t2_cnt2", 32'(bit_count), 32'h2);
    applyStimulus(1'b1, 1'b1);
    checkOutput("t2_cnt3", 32'(bit_count), 32'h3);
    checkOutput("t2_pre_valid", 32'(word_valid), 32'h0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("t2_cnt0", 32'(bit_count), 32'h0);
    checkOutput("t2_word", 32'(word_out), 32'hD);
    checkOutput("t2_valid", 32'(word_valid), 32'h1);
    tick();
    checkOutput("t2_valid_gone", 32'(word_valid), 32'h0);
    checkOutput("t2_word_hold", 32'(word_out), 32'hD);

    // Test 3: MSB-first with gaps, lsb_first toggled mid-word
    applyStimulus(1'b1, 1'b0);
    idle(3);
    applyStimulus(1'b0, 1'b0);
    idle(3);
    checkOutput("t3_gap_count", 32'(bit_count), 32'h2);
    applyStimulus(1'b0, 1'b1);
    idle(3);
    applyStimulus(1'b1, 1'b1);
    checkOutput("t3_word", 32'(word_out), 32'h9);
    checkOutput("t3_valid", 32'(word_valid), 32'h1);
    tick();

    // Test 4: backpressure, drop with simultaneous clear (set wins)
    word_ready = 1'b0;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t4_first_word", 32'(word_out), 32'hD);
    checkOutput("t4_first_ovf", 32'(overflow), 32'h0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    clear_ovf = 1'b1;
    applyStimulus(1'b0, 1'b0);
    clear_ovf = 1'b0;
    checkOutput("t4_ovf_set_wins", 32'(overflow), 32'h1);
    checkOutput("t4_word_kept", 32'(word_out), 32'hD);
    checkOutput("t4_valid_kept", 32'(word_valid), 32'h1);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    checkOutput("t4_ovf_cleared", 32'(overflow), 32'h0);
    word_ready = 1'b1;
    tick();
    checkOutput("t4_drain", 32'(word_valid), 32'h0);
    checkOutput("t4_drain_word", 32'(word_out), 32'hD);

    // Test 5: frame_start discards partial word and takes its own bit
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    frame_start = 1'b1;
    applyStimulus(1'b0, 1'b0);
    frame_start = 1'b0;
    checkOutput("t5_fs_count", 32'(bit_count), 32'h1);
    checkOutput("t5_fs_valid", 32'(word_valid), 32'h0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t5_pre_valid", 32'(word_valid), 32'h0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t5_word", 32'(word_out), 32'h6);
    checkOutput("t5_valid", 32'(word_valid), 32'h1);
    checkOutput("t5_ovf", 32'(overflow), 32'h0);
    tick();

    // Test 6: ready rises in the cycle the next word completes
    word_ready = 1'b0;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t6_word_a", 32'(word_out), 32'hA);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    word_ready = 1'b1;
    applyStimulus(1'b1, 1'b0);
    checkOutput("t6_word_b", 32'(word_out), 32'h5);
    checkOutput("t6_valid", 32'(word_valid), 32'h1);
    checkOutput("t6_ovf", 32'(overflow), 32'h0);
    tick();
    checkOutput("t6_drain", 32'(word_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
